tcu_job_arbiter: RTL and testbench
==================================

TCU_JOB_ARBITER -- requirements
Module: tcu_job_arbiter

Interface
REQ-001 Parameter DEPTH_INPUT, default 48: input words accepted per job.
REQ-002 Parameter DEPTH_OUTPUT, default 16: result words returned per job.
REQ-003 Parameter COMPUTE_DEPTH, default 12: TCU compute cycles per job.
REQ-004 Parameter TIMEOUT_CYCLES, default 1024: stall limit used by the watchdog.
REQ-005 clk  input  1  single clock, rising edge.
REQ-006 rst  input  1  synchronous, active-high reset.
REQ-007 req  input  2  per-requester job request, level, held high until done.
REQ-008 gnt  output  2  one-hot TCU ownership, high for the whole job.
REQ-009 in_valid  input  1  input word present from the granted requester.
REQ-010 in_ready  output  1  arbiter accepts an input word.
REQ-011 in_idx  output  6  index of the current input word, 0..DEPTH_INPUT-1.
REQ-012 tcu_start  output  1  one-cycle pulse that launches the TCU compute.
REQ-013 out_valid  output  1  result word available to the granted requester.
REQ-014 out_ready  input  1  granted requester takes a result word.
REQ-015 out_idx  output  4  index of the current result word, 0..DEPTH_OUTPUT-1.
REQ-016 busy  output  1  high in any state other than IDLE.
REQ-017 done  output  2  one-cycle completion pulse per requester.
REQ-018 err  output  1  one-cycle watchdog abort pulse; constant 0 when the watchdog is compiled out.

Function
REQ-019 The state machine SHALL have the states IDLE, LOAD, COMPUTE, UNLOAD and DONE.
REQ-020 IDLE with any req high -> LOAD on the next edge; gnt asserts in the same edge, so latency from req to gnt is 1 cycle.
REQ-021 Arbitration SHALL be round-robin: with both req high, the requester not served last wins; after reset, requester 0 has priority.
REQ-022 In LOAD, in_ready=1; a beat is in_valid&in_ready, and each beat increments in_idx.
REQ-023 In LOAD, in_valid low SHALL stall with no state or index change.
REQ-024 The beat with in_idx=DEPTH_INPUT-1 SHALL move LOAD -> COMPUTE; tcu_start pulses in the first COMPUTE cycle; in_idx clears.
REQ-025 COMPUTE SHALL last exactly COMPUTE_DEPTH cycles, then -> UNLOAD; in_ready=0 and out_valid=0 throughout.
REQ-026 In UNLOAD, out_valid=1; a beat is out_valid&out_ready, and each beat increments out_idx.
REQ-027 In UNLOAD, out_ready low SHALL stall with out_idx held.
REQ-028 The beat with out_idx=DEPTH_OUTPUT-1 SHALL move UNLOAD -> DONE.
REQ-029 DONE SHALL last 1 cycle: done[owner]=1, gnt=0, out_idx clears, then -> IDLE.
REQ-030 A new grant SHALL be possible at the earliest one cycle after DONE.
REQ-031 A req deassert mid-job SHALL be ignored; the job runs to completion.
REQ-032 A new req from the other requester mid-job SHALL be queued and served next.
REQ-033 gnt SHALL be one-hot or zero at all times, never 2'b11.
REQ-034 in_ready and out_valid SHALL never be high in the same cycle.

Reset
REQ-035 When rst is high at an edge: state=IDLE, gnt=0, in_ready=0, out_valid=0, tcu_start=0, busy=0, done=0, err=0, in_idx=0, out_idx=0, round-robin pointer selects requester 0.
REQ-036 Reset mid-job SHALL abort immediately with no done pulse; reset dominates every other input.

Configuration
REQ-037 With macro TCU_ARB_TIMEOUT_EN defined, a watchdog counts consecutive stall cycles in LOAD or UNLOAD, clearing on every beat.
REQ-038 With TCU_ARB_TIMEOUT_EN, when the count reaches TIMEOUT_CYCLES: state -> IDLE, err pulses 1 cycle, gnt clears, no done pulse, and the round-robin pointer advances.
REQ-039 Without TCU_ARB_TIMEOUT_EN, err is tied 0, stalls are unbounded, and no watchdog logic is present.

Verification
REQ-040 req=01, in_valid held 1, out_ready held 1 -> gnt=01 at cycle 1; tcu_start at cycle 49; first out_valid at cycle 61; done=01 at cycle 77.
REQ-041 req=11 from reset -> requester 0 served first, then requester 1; after that, req=11 again -> requester 0 served.
REQ-042 in_valid toggling 1/0 -> 96 cycles in LOAD; in_idx ends at 47 before COMPUTE; exactly one tcu_start pulse.
REQ-043 out_ready low for 5 cycles at out_idx=7 -> out_idx holds at 7, out_valid stays 1, and the remaining beats complete.
REQ-044 rst asserted at in_idx=20 -> next cycle all outputs at reset values, no done pulse; a new req is then granted normally.
REQ-045 TCU_ARB_TIMEOUT_EN defined, TIMEOUT_CYCLES=8, in_valid stuck 0 in LOAD -> err pulses after 8 stall cycles, gnt=0, state IDLE, done stays 0.

Source files
------------

// File: rtl/tcu_job_arbiter.sv
// ---------------------------------------------------------------------------
// tcu_job_arbiter
//   Grants a shared TCU to one of two requesters for a full job: stream
//   DEPTH_INPUT input words in, run COMPUTE_DEPTH compute cycles, stream
//   DEPTH_OUTPUT result words out, then pulse done for the owner.
//   Ties between requesters are broken round-robin (requester 0 first
//   after reset).
//
//   Optional watchdog: define TCU_ARB_TIMEOUT_EN to abort a job after
//   TIMEOUT_CYCLES consecutive stall cycles in LOAD or UNLOAD (err pulse,
//   no done). Without the macro err is tied low and stalls are unbounded.
//
// Ports
//   clk        in   clock, rising edge
//   rst        in   synchronous active-high reset
//   req[1:0]   in   level job request per requester
//   gnt[1:0]   out  one-hot TCU ownership for the whole job
//   in_valid   in   input word present from the owner
//   in_ready   out  input word accepted (LOAD)
//   in_idx     out  current input word index
//   tcu_start  out  one-cycle pulse in the first COMPUTE cycle
//   out_valid  out  result word available (UNLOAD)
//   out_ready  in   owner takes the result word
//   out_idx    out  current result word index
//   busy       out  high outside IDLE
//   done[1:0]  out  one-cycle completion pulse for the owner
//   err        out  one-cycle watchdog abort pulse
// ---------------------------------------------------------------------------
module tcu_job_arbiter #(
    parameter int unsigned DEPTH_INPUT    = 48,
    parameter int unsigned DEPTH_OUTPUT   = 16,
    parameter int unsigned COMPUTE_DEPTH  = 12,
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    output logic [1:0] gnt,
    input  logic       in_valid,
    output logic       in_ready,
    output logic [5:0] in_idx,
    output logic       tcu_start,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [3:0] out_idx,
    output logic       busy,
    output logic [1:0] done,
    output logic       err
);

    localparam int unsigned CW = $clog2(COMPUTE_DEPTH + 1);
    localparam logic [5:0]    LAST_IN  = 6'(DEPTH_INPUT - 1);
    localparam logic [3:0]    LAST_OUT = 4'(DEPTH_OUTPUT - 1);
    localparam logic [CW-1:0] LAST_CMP = CW'(COMPUTE_DEPTH - 1);

    // Index ports are fixed-width, so the depths must fit them.
    if (DEPTH_INPUT < 1 || DEPTH_INPUT > 64 || DEPTH_OUTPUT < 1 || DEPTH_OUTPUT > 16 ||
        COMPUTE_DEPTH < 1 || TIMEOUT_CYCLES < 1) begin : g_bad_params
        $error("tcu_job_arbiter: parameter out of range");
    end

    typedef enum logic [2:0] {StIdle, StLoad, StCompute, StUnload, StDone} state_e;

    state_e        state_q;
    logic          owner_q;    // requester currently holding the TCU
    logic          prio_q;     // requester that wins a tie
    logic [CW-1:0] cmp_cnt_q;
    logic          pick;
    logic          in_beat;
    logic          out_beat;

    assign in_beat  = in_valid & in_ready;
    assign out_beat = out_valid & out_ready;

    always_comb begin
        pick = 1'b0;
        unique case (req)
            2'b10:   pick = 1'b1;
            2'b11:   pick = prio_q;
            default: pick = 1'b0;
        endcase
    end

`ifdef TCU_ARB_TIMEOUT_EN
    localparam int unsigned WW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [WW-1:0] LAST_WDOG = WW'(TIMEOUT_CYCLES - 1);

    logic [WW-1:0] wdog_q;
    logic          err_q;
    logic          stall;

    assign stall = (state_q == StLoad && !in_beat) || (state_q == StUnload && !out_beat);
    assign err   = err_q;
`else
    assign err = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StIdle;
            owner_q   <= 1'b0;
            prio_q    <= 1'b0;
            cmp_cnt_q <= '0;
            gnt       <= 2'b00;
            in_ready  <= 1'b0;
            in_idx    <= '0;
            tcu_start <= 1'b0;
            out_valid <= 1'b0;
            out_idx   <= '0;
            busy      <= 1'b0;
            done      <= 2'b00;
`ifdef TCU_ARB_TIMEOUT_EN
            wdog_q    <= '0;
            err_q     <= 1'b0;
`endif
        end else begin
            tcu_start <= 1'b0;
            done      <= 2'b00;
            unique case (state_q)
                StIdle: begin
                    if (|req) begin
                        state_q  <= StLoad;
                        owner_q  <= pick;
                        gnt      <= pick ? 2'b10 : 2'b01;
                        in_ready <= 1'b1;
                        busy     <= 1'b1;
                    end
                end
                StLoad: begin
                    if (in_beat) begin
                        if (in_idx == LAST_IN) begin
                            state_q   <= StCompute;
                            in_idx    <= '0;
                            in_ready  <= 1'b0;
                            tcu_start <= 1'b1;
                            cmp_cnt_q <= '0;
                        end else begin
                            in_idx <= in_idx + 6'd1;
                        end
                    end
                end
                StCompute: begin
                    if (cmp_cnt_q == LAST_CMP) begin
                        state_q   <= StUnload;
                        out_valid <= 1'b1;
                    end else begin
                        cmp_cnt_q <= cmp_cnt_q + 1'b1;
                    end
                end
                StUnload: begin
                    if (out_beat) begin
                        if (out_idx == LAST_OUT) begin
                            state_q   <= StDone;
                            out_valid <= 1'b0;
                            out_idx   <= '0;
                            gnt       <= 2'b00;
                            done      <= owner_q ? 2'b10 : 2'b01;
                            prio_q    <= ~owner_q;
                        end else begin
                            out_idx <= out_idx + 4'd1;
                        end
                    end
                end
                StDone: begin
                    state_q <= StIdle;
                    busy    <= 1'b0;
                end
                default: state_q <= StIdle;
            endcase
`ifdef TCU_ARB_TIMEOUT_EN
            // Later assignments override the case above on abort.
            err_q <= 1'b0;
            if (stall) begin
                if (wdog_q == LAST_WDOG) begin
                    state_q   <= StIdle;
                    gnt       <= 2'b00;
                    in_ready  <= 1'b0;
                    out_valid <= 1'b0;
                    in_idx    <= '0;
                    out_idx   <= '0;
                    busy      <= 1'b0;
                    err_q     <= 1'b1;
                    prio_q    <= ~owner_q;
                    wdog_q    <= '0;
                end else begin
                    wdog_q <= wdog_q + 1'b1;
                end
            end else begin
                wdog_q <= '0;
            end
`endif
        end
    end

endmodule

// File: tb/tb_tcu_job_arbiter.sv
// Scoreboard bench for tcu_job_arbiter: stimulus pushes expected events
// (grant, start, first result, done, err) with their cycle numbers; a
// monitor pops and compares each event as the DUT produces it.
`timescale 1ns/1ps
module tb_tcu_job_arbiter;

    localparam int unsigned TMO = 8;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [1:0] req = 2'b00;
    logic       in_valid = 1'b0;
    logic       out_ready = 1'b0;
    logic [1:0] gnt;
    logic       in_ready;
    logic [5:0] in_idx;
    logic       tcu_start;
    logic       out_valid;
    logic [3:0] out_idx;
    logic       busy;
    logic [1:0] done;
    logic       err;

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    tcu_job_arbiter #(
        .DEPTH_INPUT   (48),
        .DEPTH_OUTPUT  (16),
        .COMPUTE_DEPTH (12),
        .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .req      (req),
        .gnt      (gnt),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_idx   (in_idx),
        .tcu_start(tcu_start),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_idx  (out_idx),
        .busy     (busy),
        .done     (done),
        .err      (err)
    );

    typedef enum logic [2:0] {EvGnt, EvStart, EvOut, EvDone, EvErr} ev_e;
    typedef struct {
        ev_e        kind;
        logic [1:0] val;
        int         at;
    } ev_t;

    ev_t exp_q[$];
    int  n_cmp = 0;
    int  n_bad = 0;

    function automatic logic [18:0] outs();
        return {gnt, in_ready, in_idx, tcu_start, out_valid, out_idx, busy, done, err};
    endfunction

    task automatic check(input string name, input int act, input int want);
        n_cmp++;
        if (act != want) begin
            n_bad++;
            $display("FAIL %s: got %0d, want %0d (cycle %0d)", name, act, want, cyc);
        end
    endtask

    task automatic push_ev(input ev_e k, input logic [1:0] v, input int at);
        ev_t e;
        e.kind = k;
        e.val  = v;
        e.at   = at;
        exp_q.push_back(e);
    endtask

    // Uninterrupted job with in_valid/out_ready held high; base is the cycle
    // in which IDLE sees the request.
    task automatic push_job(input logic [1:0] who, input int base);
        push_ev(EvGnt,   who, base + 1);
        push_ev(EvStart, who, base + 49);
        push_ev(EvOut,   who, base + 61);
        push_ev(EvDone,  who, base + 77);
    endtask

    task automatic wait_done(input int bound, output logic [1:0] seen);
        seen = 2'b00;
        for (int i = 0; i < bound; i++) begin
            @(negedge clk);
            if (done != 2'b00) begin
                seen = done;
                break;
            end
        end
        if (seen == 2'b00) begin
            n_cmp++;
            n_bad++;
            $display("FAIL done_timeout: got no done, want done within %0d cycles", bound);
        end
    endtask

    // Monitor
    logic [1:0] gnt_prev = 2'b00;
    logic       ov_prev  = 1'b0;

    task automatic observe(input ev_e k, input logic [1:0] v);
        ev_t e;
        n_cmp++;
        if (exp_q.size() == 0) begin
            n_bad++;
            $display("FAIL unexpected_event: got %s val=%b at cycle %0d, want none",
                     k.name(), v, cyc);
        end else begin
            e = exp_q.pop_front();
            if (e.kind != k || e.val != v || e.at != cyc) begin
                n_bad++;
                $display("FAIL event: got %s val=%b cycle %0d, want %s val=%b cycle %0d",
                         k.name(), v, cyc, e.kind.name(), e.val, e.at);
            end
        end
    endtask

    always @(negedge clk) begin
        if (gnt != 2'b00 && gnt_prev == 2'b00) observe(EvGnt, gnt);
        if (tcu_start) observe(EvStart, gnt);
        if (out_valid && !ov_prev) observe(EvOut, gnt);
        if (done != 2'b00) observe(EvDone, done);
        if (err) observe(EvErr, gnt);
        n_cmp++;
        if (gnt == 2'b11 || (in_ready && out_valid)) begin
            n_bad++;
            $display("FAIL invariant: got gnt=%b in_ready=%b out_valid=%b at cycle %0d, want gnt!=11 and not both ready/valid",
                     gnt, in_ready, out_valid, cyc);
        end
        gnt_prev <= gnt;
        ov_prev  <= out_valid;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got no finish, want finish before 200000ns");
        $fatal(1, "bench stopped by global timeout");
    end

    initial begin
        int         base;
        int         load_cyc;
        int         starts;
        int         last_idx;
        logic [1:0] seen;

        // Reset values
        repeat (3) @(negedge clk);
        check("reset_outputs", int'(outs()), 0);
        rst = 1'b0;

        // Single job, no stalls
        @(negedge clk);
        base = cyc;
        req = 2'b01; in_valid = 1'b1; out_ready = 1'b1;
        push_job(2'b01, base);
        wait_done(200, seen);
        req = 2'b00;

        // Round-robin from reset
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("reset_again", int'(outs()), 0);
        rst = 1'b0;
        @(negedge clk);
        base = cyc;
        req = 2'b11;
        push_job(2'b01, base);
        push_job(2'b10, base + 78);
        wait_done(200, seen);
        check("rr_first", int'(seen), 1);
        req = 2'b10;
        wait_done(200, seen);
        check("rr_second", int'(seen), 2);
        req = 2'b11;
        push_job(2'b01, cyc + 1);
        wait_done(200, seen);
        check("rr_third", int'(seen), 1);
        req = 2'b00;

        // in_valid toggling, first LOAD cycle idle
        @(negedge clk);
        base = cyc;
        req = 2'b01; in_valid = 1'b0;
        push_ev(EvGnt,   2'b01, base + 1);
        push_ev(EvStart, 2'b01, base + 97);
        push_ev(EvOut,   2'b01, base + 109);
        push_ev(EvDone,  2'b01, base + 125);
        load_cyc = 0; starts = 0; last_idx = 0; seen = 2'b00;
        for (int k = 0; k < 300 && seen == 2'b00; k++) begin
            @(negedge clk);
            in_valid = ((cyc - base) % 2 == 0);
            if (in_ready) begin
                load_cyc++;
                last_idx = int'(in_idx);
            end
            if (tcu_start) starts++;
            if (done != 2'b00) seen = done;
        end
        check("toggle_load_cycles", load_cyc, 96);
        check("toggle_last_in_idx", last_idx, 47);
        check("toggle_start_pulses", starts, 1);
        check("toggle_done", int'(seen), 1);
        req = 2'b00; in_valid = 1'b1;

        // out_ready low for 5 cycles at out_idx 7
        @(negedge clk);
        base = cyc;
        req = 2'b01;
        push_ev(EvGnt,   2'b01, base + 1);
        push_ev(EvStart, 2'b01, base + 49);
        push_ev(EvOut,   2'b01, base + 61);
        push_ev(EvDone,  2'b01, base + 82);
        seen = 2'b00;
        for (int k = 0; k < 300 && seen == 2'b00; k++) begin
            @(negedge clk);
            out_ready = !((cyc - base) >= 68 && (cyc - base) <= 72);
            if ((cyc - base) >= 68 && (cyc - base) <= 73) begin
                check("stall_out_idx", int'(out_idx), 7);
                check("stall_out_valid", int'(out_valid), 1);
            end
            if (done != 2'b00) seen = done;
        end
        check("stall_done", int'(seen), 1);
        req = 2'b00; out_ready = 1'b1;

        // Reset mid-LOAD, then a fresh job
        @(negedge clk);
        base = cyc;
        req = 2'b01;
        push_ev(EvGnt, 2'b01, base + 1);
        repeat (21) @(negedge clk);
        check("idx_before_rst", int'(in_idx), 20);
        rst = 1'b1;
        @(negedge clk);
        check("midjob_reset_outputs", int'(outs()), 0);
        rst = 1'b0;
        push_job(2'b01, cyc);
        wait_done(200, seen);
        check("after_reset_done", int'(seen), 1);
        req = 2'b00;

`ifdef TCU_ARB_TIMEOUT_EN
        // Watchdog abort with in_valid stuck low
        @(negedge clk);
        base = cyc;
        req = 2'b01; in_valid = 1'b0;
        push_ev(EvGnt, 2'b01, base + 1);
        push_ev(EvErr, 2'b00, base + 9);
        repeat (9) @(negedge clk);
        check("wdog_err", int'(err), 1);
        check("wdog_busy", int'(busy), 0);
        check("wdog_gnt", int'(gnt), 0);
        req = 2'b00; in_valid = 1'b1;
        repeat (3) @(negedge clk);
        check("wdog_err_cleared", int'(err), 0);
`endif

        repeat (5) @(negedge clk);
        check("leftover_events", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
